// File: rtl/adder_sub_pkg.sv
// Shared definitions for the add/subtract block family: FSM state encodings
// and the default operand width.
package adder_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : adder_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a_i - b_i - bin, with borrow out.
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a_i ^ b_i ^ bin;
   assign bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by macro SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
   import adder_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic             borrow_out,
   output logic             overflow
`else
   output logic             borrow_out
`endif
);

   // Counter must reach WIDTH without wrapping, hence WIDTH+1 codes.
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bin_q, bin_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic             overflow_q, overflow_d;
`endif

   logic [WIDTH-1:0] a_sh, b_sh;
   logic             d_bit, bout_bit;

   assign a_sh = a_q >> cnt_q;
   assign b_sh = b_q >> cnt_q;

   full_subtractor u_cell (
      .a_i  (a_sh[0]),
      .b_i  (b_sh[0]),
      .bin  (bin_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   always_comb begin
      // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      bin_d        = bin_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      overflow_d   = overflow_q;
`endif

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SHIFT;
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               bin_d   = 1'b0;
               res_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            res_d = {d_bit, res_q[WIDTH-1:1]};
            bin_d = bout_bit;
            cnt_d = cnt_q + CNT_W'(1);
            // Visible results change only on the final bit, never mid-operation.
            if (cnt_q == LAST_BIT) begin
               state_d      = DONE;
               diff_d       = {d_bit, res_q[WIDTH-1:1]};
               borrow_out_d = bout_bit;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
               overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: operand and result registers are reset too; cleared state is observable.
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         bin_q        <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         overflow_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         bin_q        <= bin_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         overflow_q   <= overflow_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   assign overflow   = overflow_q;
`endif

endmodule : serial_subtractor
